odd_div_cfg_ctrl: RTL

//  Run-time controller for a 50%-duty integer clock divider (odd or even ratio).

---
 rtl/odd_div_pkg.sv | 14 +
 rtl/odd_div_core.sv | 68 ++++++
 rtl/odd_div_cfg_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/odd_div_pkg.sv
// Shared types and constants for the run-time configurable clock divider.
// Imported by the datapath core and the configuration controller.
package odd_div_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int MIN_DIV   = 2;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/odd_div_core.sv
// Divider datapath: period counter, posedge/negedge phase registers,
// odd/even output select and the active divisor register.
module odd_div_core
    import odd_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 7
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic [CNT_W-1:0] cur_div,
    output logic             wrap,
    output logic             clk_out
);

    logic             act;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_q;
    logic             p;
    logic             n;
    logic             start;

    assign wrap    = act && (cnt == div_q - CNT_W'(1));
    assign cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    assign start   = run && !act;
    assign cur_div = div_q;

    // The first cycle of every period is high, so a fresh start raises p
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            act   <= 1'b0;
            cnt   <= '0;
            p     <= 1'b0;
            div_q <= CNT_W'(DIV_DEFAULT);
        end else begin
            act <= run;
            if (load) begin
                div_q <= load_div;
            end
            if (!run) begin
                cnt <= '0;
                p   <= 1'b0;
            end else if (start) begin
                cnt <= '0;
                p   <= 1'b1;
            end else begin
                cnt <= cnt_nxt;
                p   <= (cnt_nxt < (div_q >> 1));
            end
        end
    end

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            n <= 1'b0;
        end else begin
            n <= p;
        end
    end

    // Odd ratios stretch the high phase by half a source cycle
    assign clk_out = div_q[0] ? (p | n) : p;

endmodule

// File: rtl/odd_div_cfg_ctrl.sv
// Divider controller: start/stop FSM, divisor update handshake,
// boundary-aligned divisor switch, lock and error reporting.
module odd_div_cfg_ctrl
    import odd_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 7
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             locked,
    output logic             clk_out
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_nxt;
    logic [CNT_W-1:0] load_div;
    logic             load;
    logic             run;
    logic             wrap;
    logic             take;
    logic             legal;
    logic             take_ok;

    assign cfg_ready = (state != PEND);
    assign take      = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= CNT_W'(MIN_DIV));
    assign take_ok   = take && legal;
    assign run       = (state_nxt != OFF);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= OFF;
            pend_div <= CNT_W'(DIV_DEFAULT);
            cfg_err  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_div <= pend_nxt;
            cfg_err  <= take && !legal;
            locked   <= (state_nxt == RUN) && (state == RUN)
                        && (locked || wrap);
        end
    end

    // en and requests only change the running ratio at a wrap
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_div;
        load      = 1'b0;
        load_div  = cfg_div;
        unique case (state)
            OFF: begin
                load = take_ok;
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (wrap && !en) begin
                    load      = take_ok;
                    state_nxt = OFF;
                end else if (take_ok) begin
                    pend_nxt  = cfg_div;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    load      = 1'b1;
                    load_div  = pend_div;
                    state_nxt = en ? RUN : OFF;
                end
            end
            default: begin
                state_nxt = OFF;
            end
        endcase
    end

    odd_div_core #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_core (
        .clk_in   (clk_in),
        .rst      (rst),
        .run      (run),
        .load     (load),
        .load_div (load_div),
        .cur_div  (cur_div),
        .wrap     (wrap),
        .clk_out  (clk_out)
    );

endmodule
